// File: rtl/pipeline_stage_if.sv
// pipeline_stage_if: instruction-fetch stage owning the PC, fetching over
// a req/ready handshake and classifying each word for the IF/ID register.
//
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   stall                   hold IF outputs and PC (ID hazard)
//   redirect, redirect_pc   taken branch/jump target; overrides stall
//   imem_req, imem_addr     fetch request and address (= PC)
//   imem_ready, imem_rdata  fetched word valid this cycle
//   ToIFID_Inst/NewPC/InstNum/InstType  IF/ID bundle (Inst 0 = bubble)
//
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt/perf_bubble_cnt.

module pipeline_stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ToIFID_Inst,
    output logic [31:0] ToIFID_NewPC,
    output logic [3:0]  ToIFID_InstNum,
    output logic [3:0]  ToIFID_InstType
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_bubble_cnt
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_npc_q, skid_npc_d;
    logic [3:0]  skid_type_q, skid_type_d;

    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_npc_q, out_npc_d;
    logic [3:0]  out_num_q, out_num_d;
    logic [3:0]  out_type_q, out_type_d;

    logic [31:0] pc_next;
    logic [3:0]  rdata_type;

    function automatic logic [3:0] classify(input logic [31:0] w);
        logic [3:0] t;
        if (w == 32'h0) begin
            t = 4'd0;
        end else begin
            unique case (w[31:26])
                6'h00:        t = 4'd1;
                6'h23:        t = 4'd2;
                6'h2B:        t = 4'd3;
                6'h04, 6'h05: t = 4'd4;
                6'h02, 6'h03: t = 4'd5;
                6'h08, 6'h09, 6'h0A, 6'h0B,
                6'h0C, 6'h0D, 6'h0E, 6'h0F:
                              t = 4'd6;
                default:      t = 4'd15;
            endcase
        end
        return t;
    endfunction

    assign pc_next    = pc_q + STEP;
    assign rdata_type = classify(imem_rdata);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        skid_inst_d = skid_inst_q;
        skid_npc_d  = skid_npc_q;
        skid_type_d = skid_type_q;
        out_inst_d  = out_inst_q;
        out_npc_d   = out_npc_q;
        out_num_d   = out_num_q;
        out_type_d  = out_type_q;

        if (redirect) begin
            // Memory response in this cycle belongs to the wrong path.
            state_d     = FETCH;
            pc_d        = redirect_pc;
            skid_inst_d = 32'h0;
            skid_npc_d  = 32'h0;
            skid_type_d = 4'd0;
            out_inst_d  = 32'h0;
            out_type_d  = 4'd0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_next;
                        if (stall) begin
                            // Park the word; ID is not taking anything.
                            skid_inst_d = imem_rdata;
                            skid_npc_d  = pc_next;
                            skid_type_d = rdata_type;
                            state_d     = HOLD;
                        end else begin
                            out_inst_d = imem_rdata;
                            out_npc_d  = pc_next;
                            out_num_d  = cnt_q;
                            out_type_d = rdata_type;
                            cnt_d      = cnt_q + 4'd1;
                        end
                    end else if (!stall) begin
                        out_inst_d = 32'h0;
                        out_type_d = 4'd0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        out_inst_d = skid_inst_q;
                        out_npc_d  = skid_npc_q;
                        out_num_d  = cnt_q;
                        out_type_d = skid_type_q;
                        cnt_d      = cnt_q + 4'd1;
                        state_d    = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            cnt_q       <= 4'd0;
            skid_inst_q <= 32'h0;
            skid_npc_q  <= 32'h0;
            skid_type_q <= 4'd0;
            out_inst_q  <= 32'h0;
            out_npc_q   <= 32'h0;
            out_num_q   <= 4'd0;
            out_type_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            skid_inst_q <= skid_inst_d;
            skid_npc_q  <= skid_npc_d;
            skid_type_q <= skid_type_d;
            out_inst_q  <= out_inst_d;
            out_npc_q   <= out_npc_d;
            out_num_q   <= out_num_d;
            out_type_q  <= out_type_d;
        end
    end

    assign imem_req        = (state_q == FETCH);
    assign imem_addr       = pc_q;
    assign ToIFID_Inst     = out_inst_q;
    assign ToIFID_NewPC    = out_npc_q;
    assign ToIFID_InstNum  = out_num_q;
    assign ToIFID_InstType = out_type_q;

`ifdef IF_PERF_CNT_EN
    logic        fire_deliver;
    logic        fire_bubble;
    logic [15:0] perf_fetch_q, perf_fetch_d;
    logic [15:0] perf_bubble_q, perf_bubble_d;

    // Mirrors the delivery/bubble decisions of the main next-state logic.
    always_comb begin
        fire_deliver = 1'b0;
        fire_bubble  = 1'b0;
        if (!stall) begin
            if (redirect) begin
                fire_bubble = 1'b1;
            end else if (state_q == HOLD) begin
                fire_deliver = 1'b1;
            end else if (imem_ready) begin
                fire_deliver = 1'b1;
            end else begin
                fire_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        perf_fetch_d  = perf_fetch_q;
        perf_bubble_d = perf_bubble_q;
        if (fire_deliver && (perf_fetch_q != 16'hFFFF)) begin
            perf_fetch_d = perf_fetch_q + 16'd1;
        end
        if (fire_bubble && (perf_bubble_q != 16'hFFFF)) begin
            perf_bubble_d = perf_bubble_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_q  <= 16'h0;
            perf_bubble_q <= 16'h0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_if.sv
// tb_pipeline_stage_if: directed self-checking bench for pipeline_stage_if.
// Linear stimulus with hand-computed expectations checked by assertions.

module tb_pipeline_stage_if;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] new_pc;
    logic [3:0]  inst_num;
    logic [3:0]  inst_type;

    int n_chk;
    int n_fail;

    pipeline_stage_if dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .ToIFID_Inst     (inst),
        .ToIFID_NewPC    (new_pc),
        .ToIFID_InstNum  (inst_num),
        .ToIFID_InstType (inst_type)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_inst,
                           input logic [31:0] e_npc, input logic [3:0] e_num,
                           input logic [3:0] e_type);
        chk({tag, "_inst"}, inst, e_inst);
        chk({tag, "_npc"}, new_pc, e_npc);
        chk({tag, "_num"}, {28'h0, inst_num}, {28'h0, e_num});
        chk({tag, "_type"}, {28'h0, inst_type}, {28'h0, e_type});
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b1;
        imem_rdata  = 32'h8C01_0004;

        step();
        step();
        chk_out("reset", 32'h0, 32'h0, 4'd0, 4'd0);
        chk("reset_addr", imem_addr, 32'h0);

        // release away from the edge
        reset_n = 1'b1;
        chk("req_after_rst", {31'h0, imem_req}, 32'h1);

        step();
        chk_out("first", 32'h8C01_0004, 32'h4, 4'd0, 4'd2);
        imem_rdata = 32'h0022_1820;
        step();
        chk_out("second", 32'h0022_1820, 32'h8, 4'd1, 4'd1);
        imem_rdata = 32'h2001_0005;
        step();
        chk_out("imm", 32'h2001_0005, 32'hC, 4'd2, 4'd6);
        imem_rdata = 32'h0800_0040;
        step();
        chk_out("jump", 32'h0800_0040, 32'h10, 4'd3, 4'd5);

        // slow memory: three bubbles at PC 0x10
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("bubble", 32'h0, 32'h10, 4'd3, 4'd0);
            chk("bubble_addr", imem_addr, 32'h10);
            chk("bubble_req", {31'h0, imem_req}, 32'h1);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h1022_0003;
        step();
        chk_out("after_slow", 32'h1022_0003, 32'h14, 4'd4, 4'd4);

        // stall with word arriving: parked in skid buffer
        stall      = 1'b1;
        imem_rdata = 32'hAC02_0008;
        step();
        chk_out("stall_hold", 32'h1022_0003, 32'h14, 4'd4, 4'd4);
        chk("stall_req", {31'h0, imem_req}, 32'h0);
        imem_rdata = 32'hFFFF_FFFF;
        step();
        chk_out("stall_hold2", 32'h1022_0003, 32'h14, 4'd4, 4'd4);
        chk("stall_req2", {31'h0, imem_req}, 32'h0);
        stall = 1'b0;
        step();
        chk_out("skid_out", 32'hAC02_0008, 32'h18, 4'd5, 4'd3);
        chk("skid_req", {31'h0, imem_req}, 32'h1);
        chk("skid_addr", imem_addr, 32'h18);
        imem_rdata = 32'hFC00_0000;
        step();
        chk_out("unknown", 32'hFC00_0000, 32'h1C, 4'd6, 4'd15);

        // redirect while stalled with full skid buffer
        stall      = 1'b1;
        imem_rdata = 32'h8C03_0010;
        step();
        chk("park_req", {31'h0, imem_req}, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        chk_out("redir", 32'h0, 32'h1C, 4'd6, 4'd0);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_req", {31'h0, imem_req}, 32'h1);
        redirect   = 1'b0;
        stall      = 1'b0;
        imem_rdata = 32'h0043_0820;
        step();
        chk_out("redir_fetch", 32'h0043_0820, 32'h104, 4'd7, 4'd1);

        // PC wrap and sequence-tag wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        chk_out("redir2", 32'h0, 32'h104, 4'd7, 4'd0);
        redirect   = 1'b0;
        imem_rdata = 32'h8C01_0004;
        for (int i = 0; i < 9; i++) begin
            step();
            chk_out("wrap", 32'h8C01_0004, 32'hFFFF_FFFC + 32'(4 * i),
                    4'(8 + i), 4'd2);
        end
        chk("wrap_addr", imem_addr, 32'h1C);

        // async reset in HOLD with live outputs
        stall      = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("async_rst", 32'h0, 32'h0, 4'd0, 4'd0);
        chk("async_rst_addr", imem_addr, 32'h0);
        #3;
        reset_n    = 1'b1;
        stall      = 1'b0;
        imem_rdata = 32'h8C01_0004;
        step();
        chk_out("post_rst", 32'h8C01_0004, 32'h4, 4'd0, 4'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_stage_if.md
Name: pipeline_stage_if

Overview:
- Instruction-fetch stage. Owns the PC, issues fetches to instruction memory over a req/ready handshake, and classifies each fetched word.
- Drives the IF/ID pipeline register with Inst, NewPC (PC+4), InstNum (4-bit sequence tag) and InstType.
- Honours the stall from the hazard unit and the redirect from branch/jump resolution.
- Inserts bubbles (all-zero instruction) when memory is slow or after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold IF outputs and PC (ID hazard)
redirect  in  1  branch/jump taken; overrides stall
redirect_pc  in  32  target PC when redirect=1
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= PC register)
imem_ready  in  1  imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
ToIFID_Inst  out  32  instruction, 0 = bubble
ToIFID_NewPC  out  32  fetch PC + PC_STEP
ToIFID_InstNum  out  4  sequence tag of delivered instruction
ToIFID_InstType  out  4  instruction class

Behaviour:
- Reset (reset_n=0, async):
  - PC=RESET_PC, state=FETCH, sequence counter=0, skid buffer empty.
  - All ToIFID_* = 0.
  - imem_req = 1 from the first clock edge after release.
- States:
  - FETCH: imem_req=1, imem_addr=PC.
  - HOLD: imem_req=0; a fetched word is parked in the skid buffer.
- FETCH, imem_ready=1, stall=0, redirect=0:
  - Next edge: ToIFID_Inst=imem_rdata, NewPC=PC+PC_STEP, InstNum=counter, InstType=class(imem_rdata).
  - PC+=PC_STEP, counter+=1; counter wraps 15->0.
  - Latency: one cycle from ready to outputs.
- FETCH, imem_ready=1, stall=1:
  - Word, PC+PC_STEP and class go to the skid buffer; PC advances.
  - Go to HOLD. Outputs hold.
- FETCH, imem_ready=0:
  - stall=0: outputs become a bubble (Inst=0, InstType=0, NewPC and InstNum hold).
  - stall=1: outputs hold.
  - PC holds. imem_addr stays stable while req=1 and ready=0.
- HOLD, stall=1: everything holds.
- HOLD, stall=0: next edge delivers the skid buffer to outputs with InstNum=counter, counter+=1, state=FETCH.
- redirect=1, any state, highest priority after reset:
  - Next edge: PC=redirect_pc, skid buffer discarded, state=FETCH, outputs bubble.
  - Applies even when stall=1.
  - imem_ready/imem_rdata in the redirect cycle are ignored; PC does not advance and counter does not increment.
  - Memory may abandon an outstanding request when imem_addr changes.
- redirect_pc used as-is; bits[1:0] not checked.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 = 0.
- InstType (by imem_rdata):
  - 0 NOP (word == 0)
  - 1 R-type (op[31:26]=0, word != 0)
  - 2 load (op=0x23)
  - 3 store (op=0x2B)
  - 4 branch (op=0x04/0x05)
  - 5 jump (op=0x02/0x03)
  - 6 immediate ALU (op=0x08..0x0F)
  - 15 unknown (all other opcodes)
- Bubbles never increment the counter.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[15:0] (real instructions delivered) and perf_bubble_cnt[15:0] (cycles a bubble was emitted, stall=0).
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: no ports, no logic.

Test Plan:
- Reset release, imem_ready=1 always, rdata=0x8C010004 then 0x00221820 -> first edge: Inst=0x8C010004, NewPC=4, InstNum=0, InstType=2; next edge: Inst=0x00221820, NewPC=8, InstNum=1, InstType=1.
- ready low 3 cycles at PC=0x10 -> 3 bubble cycles (Inst=0), imem_addr stays 0x10; then word delivered with NewPC=0x14.
- stall=1 in the cycle ready=1 with rdata=0xAC020008 -> outputs hold, imem_req=0 while stalled; after stall drops, one edge later Inst=0xAC020008, InstType=3, no word lost or duplicated.
- redirect=1, redirect_pc=0x100 with stall=1 and skid buffer full -> next edge: bubble, imem_addr=0x100, buffered word never appears; next fetch gives NewPC=0x104.
- Deliver 17 sequential instructions -> InstNum runs 0..15, 0; PC wrap from 0xFFFFFFFC gives NewPC=0.
- reset_n pulsed low mid-HOLD with outputs nonzero -> all outputs 0 immediately (asynchronous); after release, fetch resumes at RESET_PC with InstNum=0.
